// File: rtl/yc_redport_pkg.sv
// Shared definitions for clocked interfaces into the Morphle ycell array:
// dual-rail value encodings and the initiator FSM state type.
package yc_redport_pkg;

    localparam logic [1:0] VEMPTY = 2'b00;
    localparam logic [1:0] V0     = 2'b01;
    localparam logic [1:0] V1     = 2'b10;
    localparam logic [1:0] VERR   = 2'b11;

    localparam int WAIT_W = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RELEASE = 2'd2,
        ERROR   = 2'd3
    } yc_state_e;

    function automatic logic [1:0] dr_encode(input logic b);
        return {b, ~b};
    endfunction

    function automatic logic dr_is_value(input logic [1:0] v);
        return (v == V0) || (v == V1);
    endfunction

endpackage

// File: rtl/yc_sync2.sv
// Multi-flop synchronizer for signals crossing into the clk domain.
module yc_sync2 #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain; the first flop samples the asynchronous input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/yc_redport.sv
// Red-cell initiator: injects one dual-rail value into an edge ycell and
// collects the array's answer through a valid/ready result register.
module yc_redport
    import yc_redport_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_bit,
    input  logic       out_ready,
    output logic [1:0] aout,
    input  logic [1:0] ain,
    output logic       aempty,
    output logic       err
);

    localparam logic [WAIT_W:0] TMO_C = (WAIT_W+1)'(TIMEOUT);

    logic [1:0]        sa_s;
    yc_state_e         state_r, state_nxt_s;
    logic [1:0]        aout_r, aout_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic              out_bit_r, out_bit_nxt_s;
    logic              err_r, err_nxt_s;
    logic              aempty_r;
    logic [WAIT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WAIT_W:0]   cnt_inc_s;
    logic              timeout_s;
    logic              in_ready_s;
    logic              pop_s;

    yc_sync2 #(
        .WIDTH (2),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ain),
        .q       (sa_s)
    );

    // The port stays closed while aempty is still isolating the edge cell.
    assign in_ready_s = (state_r == IDLE) && (sa_s == VEMPTY) && !aempty_r;
    assign pop_s      = out_valid_r && out_ready;
    assign cnt_inc_s  = {1'b0, cnt_r} + (WAIT_W+1)'(1);
    assign timeout_s  = (TMO_C != '0) && (cnt_inc_s == TMO_C);

    // Next-state, drive value and result register decisions.
    always_comb begin
        state_nxt_s     = state_r;
        aout_nxt_s      = aout_r;
        out_bit_nxt_s   = out_bit_r;
        err_nxt_s       = err_r;
        out_valid_nxt_s = pop_s ? 1'b0 : out_valid_r;
        case (state_r)
            IDLE: begin
                if (sa_s == VERR) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = 1'b1;
                    aout_nxt_s  = VEMPTY;
                end else if (in_valid && in_ready_s) begin
                    state_nxt_s = DRIVE;
                    aout_nxt_s  = dr_encode(in_bit);
                end else begin
                    aout_nxt_s  = VEMPTY;
                end
            end
            DRIVE: begin
                if (sa_s == VERR) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = 1'b1;
                    aout_nxt_s  = VEMPTY;
                end else if (dr_is_value(sa_s) && (!out_valid_r || out_ready)) begin
                    state_nxt_s     = RELEASE;
                    aout_nxt_s      = VEMPTY;
                    out_bit_nxt_s   = sa_s[1];
                    out_valid_nxt_s = 1'b1;
                end else if (timeout_s) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = 1'b1;
                    aout_nxt_s  = VEMPTY;
                end else begin
                    state_nxt_s = DRIVE;
                end
            end
            RELEASE: begin
                aout_nxt_s = VEMPTY;
                if (sa_s == VERR) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = 1'b1;
                end else if (sa_s == VEMPTY) begin
                    state_nxt_s = IDLE;
                end else if (timeout_s) begin
                    state_nxt_s = ERROR;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = RELEASE;
                end
            end
            ERROR: begin
                state_nxt_s = ERROR;
                aout_nxt_s  = VEMPTY;
            end
            default: begin
                state_nxt_s = ERROR;
                err_nxt_s   = 1'b1;
                aout_nxt_s  = VEMPTY;
            end
        endcase
    end

    // Wait counter restarts on every state change and runs only while waiting on the array.
    always_comb begin
        if (state_nxt_s != state_r) begin
            cnt_nxt_s = '0;
        end else if ((state_r == DRIVE) || (state_r == RELEASE)) begin
            cnt_nxt_s = cnt_r + WAIT_W'(1);
        end else begin
            cnt_nxt_s = '0;
        end
    end

    // State and output registers; reset clears the array drive asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            aout_r      <= VEMPTY;
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            err_r       <= 1'b0;
            cnt_r       <= '0;
            aempty_r    <= 1'b1;
        end else begin
            state_r     <= state_nxt_s;
            aout_r      <= aout_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_bit_r   <= out_bit_nxt_s;
            err_r       <= err_nxt_s;
            cnt_r       <= cnt_nxt_s;
            aempty_r    <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_bit   = out_bit_r;
    assign aout      = aout_r;
    assign aempty    = aempty_r;
    assign err       = err_r;

endmodule

// File: tb/tb_yc_redport.sv
// Self-checking bench for yc_redport: directed scenarios plus a random
// stream checked against an in-order queue model with an array delay model.
module tb_yc_redport;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset_n, in_valid, in_bit, out_ready;
    logic       in_ready, out_valid, out_bit, aempty, err;
    logic [1:0] aout, ain;

    logic       in_valid_t;
    logic       t8_in_ready, t8_out_valid, t8_out_bit, t8_aempty, t8_err;
    logic       t0_in_ready, t0_out_valid, t0_out_bit, t0_aempty, t0_err;
    logic [1:0] t8_aout, t0_aout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] arr_ain, arr_last;
    int  arr_cnt, arr_dly;
    int  ans_min = 3, ans_max = 3, rel_min = 2, rel_max = 2;
    bit  force11 = 1'b0;

    always #5 clk = ~clk;

    assign ain = force11 ? 2'b11 : arr_ain;

    yc_redport #(.SYNC_STAGES(SS), .TIMEOUT(1023)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit),
        .out_ready(out_ready), .aout(aout), .ain(ain), .aempty(aempty), .err(err)
    );

    yc_redport #(.SYNC_STAGES(SS), .TIMEOUT(8)) dut_t8 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_t), .in_bit(1'b1),
        .in_ready(t8_in_ready), .out_valid(t8_out_valid), .out_bit(t8_out_bit),
        .out_ready(1'b0), .aout(t8_aout), .ain(2'b00), .aempty(t8_aempty), .err(t8_err)
    );

    yc_redport #(.SYNC_STAGES(SS), .TIMEOUT(0)) dut_t0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_t), .in_bit(1'b1),
        .in_ready(t0_in_ready), .out_valid(t0_out_valid), .out_bit(t0_out_bit),
        .out_ready(1'b0), .aout(t0_aout), .ain(2'b00), .aempty(t0_aempty), .err(t0_err)
    );

    // Array model: echoes aout onto ain a chosen number of cycles after aout changes.
    initial begin
        arr_ain = 2'b00; arr_last = 2'b00; arr_cnt = 0; arr_dly = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                arr_ain = 2'b00; arr_last = 2'b00; arr_cnt = 0;
            end else if (aout !== arr_last) begin
                arr_last = aout;
                arr_cnt  = 0;
                arr_dly  = (aout != 2'b00) ? int'($urandom_range(ans_max, ans_min))
                                           : int'($urandom_range(rel_max, rel_min));
            end else if (arr_ain !== arr_last) begin
                arr_cnt++;
                if (arr_cnt >= arr_dly) arr_ain = arr_last;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input int bound, output bit ok);
        for (int i = 0; i < bound && !in_ready; i++) @(negedge clk);
        ok = in_ready;
    endtask

    task automatic wait_valid(input int bound, output bit ok);
        for (int i = 0; i < bound && !out_valid; i++) @(negedge clk);
        ok = out_valid;
    endtask

    task automatic accept(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0; in_valid_t = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (aout !== 2'b00) $display("FAIL reset_aout: got %b expected 00", aout);
        n_checks++; if (aempty !== 1'b1) $display("FAIL reset_aempty: got %b expected 1", aempty);
        n_checks++; if ({out_valid, out_bit, err} !== 3'b000) $display("FAIL reset_outs: got %b expected 000", {out_valid, out_bit, err});
        n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        if (aout !== 2'b00 || aempty !== 1'b1 || {out_valid, out_bit, err} !== 3'b000 || in_ready !== 1'b0) n_fail++;
        reset_n = 1'b1;
        #1;
        n_checks++; if (aempty !== 1'b1) begin n_fail++; $display("FAIL release_aempty_hold: got %b expected 1", aempty); end
        @(posedge clk); @(negedge clk);
        n_checks++; if (aempty !== 1'b0) begin n_fail++; $display("FAIL release_aempty_drop: got %b expected 0", aempty); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_timeout();
        int lat;
        n_checks++; if ({t8_in_ready, t0_in_ready} !== 2'b11) begin n_fail++; $display("FAIL tmo_ready: got %b expected 11", {t8_in_ready, t0_in_ready}); end
        in_valid_t = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_t = 1'b0;
        n_checks++; if (t8_aout !== 2'b10) begin n_fail++; $display("FAIL tmo_drive: got %b expected 10", t8_aout); end
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            if (t8_err) begin lat = k; break; end
        end
        n_checks++; if (lat != 8) begin n_fail++; $display("FAIL tmo8_latency: got %0d expected 8", lat); end
        n_checks++; if ({t8_aout, t8_in_ready, t8_out_valid, t8_out_bit, t8_aempty} !== 6'b000000) begin
            n_fail++; $display("FAIL tmo8_error_outs: got %b expected 000000", {t8_aout, t8_in_ready, t8_out_valid, t8_out_bit, t8_aempty});
        end
        repeat (200) @(negedge clk);
        n_checks++; if ({t0_err, t0_aout, t0_out_valid, t0_out_bit, t0_aempty} !== 6'b010000) begin
            n_fail++; $display("FAIL tmo0_waiting: got %b expected 010000", {t0_err, t0_aout, t0_out_valid, t0_out_bit, t0_aempty});
        end
    endtask

    task automatic test_single_one();
        bit ok; int lat;
        ans_min = 3; ans_max = 3; rel_min = 2; rel_max = 2; out_ready = 1'b0;
        wait_ready(20, ok);
        accept(1'b1);
        n_checks++; if (aout !== 2'b10) begin n_fail++; $display("FAIL one_aout: got %b expected 10", aout); end
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        n_checks++; if (lat != 3 + SS + 1) begin n_fail++; $display("FAIL one_latency: got %0d expected %0d", lat, 3 + SS + 1); end
        n_checks++; if ({out_bit, aout} !== 3'b100) begin n_fail++; $display("FAIL one_capture: got %b expected 100", {out_bit, aout}); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL one_pop: got %b expected 0", out_valid); end
        wait_ready(20, ok);
        n_checks++; if (!ok || err !== 1'b0) begin n_fail++; $display("FAIL one_back_idle: got ready=%b err=%b expected 1 0", in_ready, err); end
    endtask

    task automatic test_stall();
        bit ok1, ok2, ok3;
        ans_min = 3; ans_max = 3; rel_min = 2; rel_max = 2; out_ready = 1'b0;
        accept(1'b1);
        wait_valid(30, ok1);
        wait_ready(30, ok2);
        n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL stall_setup: got %b%b expected 11", ok1, ok2); end
        accept(1'b0);
        n_checks++; if (aout !== 2'b01) begin n_fail++; $display("FAIL stall_aout: got %b expected 01", aout); end
        repeat (12) @(negedge clk);
        n_checks++; if ({aout, out_valid, out_bit} !== 4'b0111) begin n_fail++; $display("FAIL stall_hold: got %b expected 0111", {aout, out_valid, out_bit}); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        n_checks++; if ({aout, out_valid, out_bit} !== 4'b0010) begin n_fail++; $display("FAIL stall_pop_capture: got %b expected 0010", {aout, out_valid, out_bit}); end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_final_pop: got %b expected 0", out_valid); end
        wait_ready(30, ok3);
        n_checks++; if (!ok3) begin n_fail++; $display("FAIL stall_back_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_error11();
        bit ok1, ok2;
        ans_min = 3; ans_max = 3; rel_min = 2; rel_max = 2; out_ready = 1'b0;
        accept(1'b1);
        wait_valid(30, ok1);
        wait_ready(30, ok2);
        accept(1'b0);
        force11 = 1'b1;
        for (int i = 0; i < 10 && !err; i++) @(negedge clk);
        n_checks++; if (!(ok1 && ok2) || err !== 1'b1) begin n_fail++; $display("FAIL err11_set: got %b expected 1", err); end
        n_checks++; if ({aout, in_ready, out_valid, out_bit} !== 5'b00011) begin n_fail++; $display("FAIL err11_outs: got %b expected 00011", {aout, in_ready, out_valid, out_bit}); end
        force11 = 1'b0;
        in_valid = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if ({err, in_ready, aout} !== 4'b1000) begin n_fail++; $display("FAIL err11_absorb: got %b expected 1000", {err, in_ready, aout}); end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL err11_pop: got %b expected 0", out_valid); end
        pulse_reset();
        n_checks++; if ({err, in_ready} !== 2'b01) begin n_fail++; $display("FAIL err11_cleared: got %b expected 01", {err, in_ready}); end
    endtask

    task automatic test_reset_release();
        bit ok;
        ans_min = 3; ans_max = 3; rel_min = 8; rel_max = 8; out_ready = 1'b0;
        wait_ready(20, ok);
        accept(1'b1);
        wait_valid(30, ok);
        n_checks++; if (!ok || aout !== 2'b00) begin n_fail++; $display("FAIL rst_setup: got %b expected 00", aout); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if ({aout, out_valid, aempty} !== 4'b0001) begin n_fail++; $display("FAIL rst_abort: got %b expected 0001", {aout, out_valid, aempty}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++; if (aempty !== 1'b1) begin n_fail++; $display("FAIL rst_aempty_hold: got %b expected 1", aempty); end
        @(posedge clk); @(negedge clk);
        n_checks++; if ({aempty, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_live: got %b expected 01", {aempty, in_ready}); end
    endtask

    task automatic test_back_to_back();
        logic exp_q[$];
        logic exp_b;
        int sent, popped, cycles;
        ans_min = 1; ans_max = 4; rel_min = 1; rel_max = 4;
        sent = 0; popped = 0; cycles = 0;
        while ((sent < 100 || exp_q.size() != 0) && cycles < 8000) begin
            @(negedge clk);
            cycles++;
            in_valid  = (sent < 100) && ($urandom_range(3, 0) != 0);
            in_bit    = 1'($urandom_range(1, 0));
            out_ready = (sent >= 100) ? 1'b1 : 1'($urandom_range(1, 0));
            if (in_valid && in_ready) begin
                exp_q.push_back(in_bit);
                sent++;
            end
            if (out_valid && out_ready) begin
                popped++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got %b with nothing outstanding", out_bit);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (out_bit !== exp_b) begin n_fail++; $display("FAIL stream_bit%0d: got %b expected %b", popped, out_bit, exp_b); end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (sent != 100 || popped != 100) begin n_fail++; $display("FAIL stream_count: got sent=%0d popped=%0d expected 100 100", sent, popped); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL stream_err: got %b expected 0", err); end
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_single_one();
        test_stall();
        test_error11();
        test_reset_release();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/yc_redport.md
YC_REDPORT -- requirements
Module: yc_redport

Synchronous "red cell" initiator: injects single dual-rail values into an edge ycell of a Morphle array and collects the final result with a four-phase handshake.

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flops in the ain synchronizer, legal 2..4.
REQ-002 Parameter TIMEOUT, default 1023: maximum cycles spent waiting in DRIVE or RELEASE; 0 disables the check.
REQ-003 clk  input  1  single clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  a value to inject is offered.
REQ-006 in_bit  input  1  the value to inject.
REQ-007 in_ready  output  1  the port accepts in_bit on this edge.
REQ-008 out_valid  output  1  a result is held in out_bit.
REQ-009 out_bit  output  1  the result value.
REQ-010 out_ready  input  1  the consumer takes out_bit on this edge.
REQ-011 aout  output  2  dual-rail value to the array: 00 empty, 01 zero, 10 one; drives lin/uin of the edge cell.
REQ-012 ain  input  2  dual-rail result from the array (lout/uout of the edge cell); asynchronous to clk.
REQ-013 aempty  output  1  isolation flag driven to the edge cell's lempty/uempty input.
REQ-014 err  output  1  sticky protocol error.

Function
REQ-015 ain SHALL pass through a SYNC_STAGES flop synchronizer; all decisions SHALL use the synchronized value sa.
REQ-016 FSM states SHALL be IDLE, DRIVE, RELEASE and ERROR; aout and aempty SHALL be registered outputs.
REQ-017 IDLE: aout=00; in_ready=1 only in IDLE and only when sa==00; a transfer (in_valid & in_ready) SHALL load aout={in_bit,~in_bit} on the same edge and enter DRIVE.
REQ-018 DRIVE: aout held; on sa==01 or sa==10 the FSM SHALL capture out_bit=sa[1], set out_valid, drive aout=00 and enter RELEASE, all on one edge.
REQ-019 DRIVE capture SHALL stall while out_valid=1 and out_ready=0; capture SHALL be allowed on the same edge as a consumer pop.
REQ-020 RELEASE: aout=00; on sa==00 the FSM SHALL enter IDLE.
REQ-021 out_valid SHALL clear on out_valid & out_ready unless a new capture occurs on the same edge, in which case it SHALL stay 1 with the new out_bit.
REQ-022 sa==11 in any state other than ERROR SHALL set err, force aout=00 and enter ERROR.
REQ-023 A 10-bit wait counter SHALL clear on each state entry and increment each cycle in DRIVE and RELEASE; when TIMEOUT!=0 and the count reaches TIMEOUT, the FSM SHALL set err, force aout=00 and enter ERROR.
REQ-024 ERROR SHALL be absorbing until reset: in_ready=0, aout=00; a result already held SHALL still be poppable.
REQ-025 aempty SHALL be 0 in all states except the first cycle after reset release, so the edge cell oscillates only after the port is live.
REQ-026 Minimum round trip, from accept at edge 0 to out_valid: (array delay rounded up to whole cycles) + SYNC_STAGES + 1 edges.
REQ-027 in_valid SHALL be ignored outside IDLE; in_bit SHALL be sampled only on a transfer.

Reset
REQ-028 While reset_n=0: state=IDLE, aout=00, aempty=1, out_valid=0, out_bit=0, err=0, counter=0, synchronizer=00, in_ready=0.
REQ-029 Reset assertion in the middle of a transaction SHALL abort it immediately; aout=00 SHALL be asynchronous with reset assertion.

Structure
REQ-030 A shared package SHALL hold the dual-rail constants (VEMPTY=2'b00, V0=2'b01, V1=2'b10) and the FSM state enum, and SHALL be reused by future clocked array interfaces.
REQ-031 The synchronizer SHALL be a separate sub-module, yc_sync2 (parameterized width and depth); everything else SHALL be flat.

Verification
REQ-032 in_bit=1 accepted, array model answers 10 after 3 cycles and returns to 00 after 2 cycles -> aout=10, then 00; out_bit=1 exactly 3+SYNC_STAGES+1 edges after accept; back in IDLE.
REQ-033 in_bit=0 with out_ready held low from a previous result -> FSM waits in DRIVE with aout=01; raising out_ready pops the old result and captures the new value (out_bit=0) on the same edge.
REQ-034 ain forced to 11 during DRIVE -> err=1, aout=00, in_ready stays 0 until reset_n is pulsed.
REQ-035 TIMEOUT=8 with the array never answering -> err=1 exactly 8 cycles after DRIVE entry; TIMEOUT=0 -> the port waits indefinitely.
REQ-036 reset_n pulsed low while in RELEASE -> aout=00 and out_valid=0 immediately; aempty=1 for one cycle after release.
REQ-037 100 back-to-back random bits with a random-delay array model and random out_ready -> output stream equals input stream, no loss or duplication, err=0.
